// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icodes, status codes and memory-stage FSM encoding shared across pipeline stages
package y86_pkg;
  localparam logic [3:0] HALT   = 4'h0;
  localparam logic [3:0] NOP    = 4'h1;
  localparam logic [3:0] RRMOVQ = 4'h2;
  localparam logic [3:0] IRMOVQ = 4'h3;
  localparam logic [3:0] RMMOVQ = 4'h4;
  localparam logic [3:0] MRMOVQ = 4'h5;
  localparam logic [3:0] OPQ    = 4'h6;
  localparam logic [3:0] JXX    = 4'h7;
  localparam logic [3:0] CALL   = 4'h8;
  localparam logic [3:0] RET    = 4'h9;
  localparam logic [3:0] PUSHQ  = 4'hA;
  localparam logic [3:0] POPQ   = 4'hB;
  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;
  function automatic logic is_write(input logic [3:0] ic);
    return ic == RMMOVQ || ic == PUSHQ || ic == CALL;
  endfunction
  function automatic logic is_read(input logic [3:0] ic);
    return ic == MRMOVQ || ic == POPQ || ic == RET;
  endfunction
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-side input handshake and writeback-side output handshake of the memory stage
interface memory_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic        cond;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic [2:0]  stat_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valM;
  logic [63:0] valE_out;
  logic [3:0]  icode_out;
  logic        cond_out;
  logic [2:0]  stat;
  modport slave (
    input  in_valid, icode, cond, valE, valA, valP, stat_in, out_ready,
    output in_ready, out_valid, valM, valE_out, icode_out, cond_out, stat
  );
  modport master (
    output in_valid, icode, cond, valE, valA, valP, stat_in, out_ready,
    input  in_ready, out_valid, valM, valE_out, icode_out, cond_out, stat
  );
endinterface

// File: rtl/data_mem_byte.sv
// data_mem_byte: byte-wide data RAM, synchronous write, asynchronous read, contents survive reset
module data_mem_byte #(
  parameter int MEM_BYTES = 1024,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [MEM_BYTES];
  always_ff @(posedge clock)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 memory stage; decodes the op, checks the address and runs an 8-beat
// little-endian byte access against data_mem_byte, then holds results until writeback takes them
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input logic           clock,
  input logic           reset,
  memory_stage_if.slave bus
);
  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
  state_t      state;
  logic [2:0]  beat;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        wr;
  logic [63:0] val_m;
  logic [63:0] val_e;
  logic [3:0]  ic_q;
  logic        cond_q;
  logic [2:0]  stat_q;
  logic        accept;
  logic        mem_op;
  logic [63:0] addr_d;
  logic [63:0] wdata_d;
  logic [2:0]  stat_d;
  logic        go;
  logic [63:0] byte_addr;
  logic [7:0]  rdata;
  logic        we;
  assign accept = bus.in_valid && state == IDLE;
  always_comb begin
    mem_op  = is_write(bus.icode) || is_read(bus.icode);
    addr_d  = (bus.icode == POPQ || bus.icode == RET) ? bus.valA : bus.valE;
    wdata_d = bus.icode == CALL ? bus.valP : bus.valA;
    stat_d  = bus.stat_in != AOK ? bus.stat_in :
              bus.icode == HALT ? HLT :
              (mem_op && addr_d > ADDR_MAX) ? ADR : AOK;
    go      = mem_op && stat_d == AOK;
  end
  // addr was range-checked on accept, so addr+beat never leaves the array
  assign byte_addr = addr + 64'(beat);
  assign we = state == ACCESS && wr;
  data_mem_byte #(.MEM_BYTES(MEM_BYTES)) u_mem (
    .clock (clock),
    .we    (we),
    .addr  (byte_addr[AW-1:0]),
    .wdata (wdata[{beat, 3'b000} +: 8]),
    .rdata (rdata)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      beat   <= '0;
      addr   <= '0;
      wdata  <= '0;
      wr     <= 1'b0;
      val_m  <= '0;
      val_e  <= '0;
      ic_q   <= '0;
      cond_q <= 1'b0;
      stat_q <= AOK;
    end else if (state == IDLE) begin
      if (accept) begin
        state  <= go ? ACCESS : DONE;
        beat   <= '0;
        addr   <= addr_d;
        wdata  <= wdata_d;
        wr     <= is_write(bus.icode);
        val_m  <= '0;
        val_e  <= bus.valE;
        ic_q   <= bus.icode;
        cond_q <= bus.cond;
        stat_q <= stat_d;
      end
    end else if (state == ACCESS) begin
      if (!wr) val_m[{beat, 3'b000} +: 8] <= rdata;
      beat <= beat + 3'd1;
      if (beat == 3'd7) state <= DONE;
    end else if (bus.out_ready) begin
      state <= IDLE;
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.valM      = val_m;
  assign bus.valE_out  = val_e;
  assign bus.icode_out = ic_q;
  assign bus.cond_out  = cond_q;
  assign bus.stat      = stat_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed vectors for memory_stage with hand-computed expectations
module tb_memory_stage;
  import y86_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  memory_stage_if bus();
  memory_stage #(.MEM_BYTES(1024)) dut (.clock(clock), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  int lat;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p, input logic c, input logic [2:0] s);
    @(negedge clock);
    bus.icode = ic; bus.valE = e; bus.valA = a; bus.valP = p; bus.cond = c; bus.stat_in = s;
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    lat = 1;
  endtask
  task automatic wait_done;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask
  task automatic op(input string tag, input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                    input logic [63:0] p, input logic c, input logic [2:0] s,
                    input int exp_lat, input logic [63:0] exp_m, input logic [2:0] exp_s);
    issue(ic, e, a, p, c, s);
    wait_done();
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " valM"}, bus.valM, exp_m);
    chk({tag, " stat"}, 64'(bus.stat), 64'(exp_s));
    chk({tag, " valE_out"}, bus.valE_out, e);
    chk({tag, " icode_out"}, 64'(bus.icode_out), 64'(ic));
    chk({tag, " cond_out"}, 64'(bus.cond_out), 64'(c));
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd0);
    @(posedge clock); #1;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.icode = '0; bus.cond = 1'b0;
    bus.valE = '0; bus.valA = '0; bus.valP = '0; bus.stat_in = AOK;
    #12;
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst valM", bus.valM, 64'd0);
    chk("rst stat", 64'(bus.stat), 64'd1);
    chk("rst valE_out", bus.valE_out, 64'd0);
    @(negedge clock) reset = 1'b0;
    op("rmmovq", RMMOVQ, 64'h100, 64'h1122334455667788, 64'h0, 1'b0, AOK, 9, 64'h0, AOK);
    chk("ram 100", 64'(dut.u_mem.mem[10'h100]), 64'h88);
    chk("ram 103", 64'(dut.u_mem.mem[10'h103]), 64'h55);
    chk("ram 107", 64'(dut.u_mem.mem[10'h107]), 64'h11);
    op("mrmovq", MRMOVQ, 64'h100, 64'h0, 64'h0, 1'b0, AOK, 9, 64'h1122334455667788, AOK);
    op("call", CALL, 64'h3F8, 64'h0, 64'h42, 1'b0, AOK, 9, 64'h0, AOK);
    op("ret", RET, 64'h400, 64'h3F8, 64'h0, 1'b1, AOK, 9, 64'h42, AOK);
    op("mr adr", MRMOVQ, 64'h3F9, 64'h0, 64'h0, 1'b0, AOK, 1, 64'h0, ADR);
    op("mr edge", MRMOVQ, 64'h3F8, 64'h0, 64'h0, 1'b0, AOK, 9, 64'h42, AOK);
    op("rm wrap", RMMOVQ, 64'hFFFFFFFFFFFFFFFC, 64'hDEADBEEFDEADBEEF, 64'h0, 1'b0, AOK, 1, 64'h0, ADR);
    op("wrap kept", MRMOVQ, 64'h3F8, 64'h0, 64'h0, 1'b0, AOK, 9, 64'h42, AOK);
    op("opq", OPQ, 64'h1234, 64'h5, 64'h0, 1'b1, AOK, 1, 64'h0, AOK);
    op("halt", HALT, 64'h0, 64'h0, 64'h0, 1'b0, AOK, 1, 64'h0, HLT);
    op("ins rm", RMMOVQ, 64'h100, 64'h0, 64'h0, 1'b0, INS, 1, 64'h0, INS);
    op("ins kept", MRMOVQ, 64'h100, 64'h0, 64'h0, 1'b0, AOK, 9, 64'h1122334455667788, AOK);
    bus.out_ready = 1'b0;
    issue(MRMOVQ, 64'h100, 64'h0, 64'h0, 1'b0, AOK);
    wait_done();
    chk("bp latency", 64'(lat), 64'd9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      chk("bp out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp valM", bus.valM, 64'h1122334455667788);
    end
    @(negedge clock) bus.out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp release", 64'(bus.in_ready), 64'd1);
    op("pre", RMMOVQ, 64'h200, 64'hAAAAAAAAAAAAAAAA, 64'h0, 1'b0, AOK, 9, 64'h0, AOK);
    issue(RMMOVQ, 64'h200, 64'h0102030405060708, 64'h0, 1'b1, AOK);
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("arst in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst valE_out", bus.valE_out, 64'd0);
    chk("arst icode_out", 64'(bus.icode_out), 64'd0);
    chk("arst cond_out", 64'(bus.cond_out), 64'd0);
    chk("arst stat", 64'(bus.stat), 64'd1);
    @(negedge clock) reset = 1'b0;
    op("partial", MRMOVQ, 64'h200, 64'h0, 64'h0, 1'b0, AOK, 9, 64'hAAAAAAAA05060708, AOK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
